// File: rtl/bean_obstacle_gen.sv
// Tick generator and moving bean obstacle for the 640x480 goose-runner.
// Optional build macro BEAN_SPEEDUP_EN: each wrap speeds the bean up, capped at MAX_SPEED.
module bean_obstacle_gen #(
    parameter int FAST_DIV   = 4000000,
    parameter int SLOW_RATIO = 10,
    parameter int X_START    = 640,
    parameter int BEAN_W     = 16,
    parameter int BEAN_H     = 24,
    parameter int FLOOR_Y    = 400,
    parameter int SPEED      = 4,
    parameter int MAX_SPEED  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        check_hit,
    output logic        tick_fast,
    output logic        tick_slow,
    output logic        bean,
    output logic [11:0] bean_rgb
);

    localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam int SW = (SLOW_RATIO > 1) ? $clog2(SLOW_RATIO) : 1;
    // Speed register is wide enough for whichever of SPEED / MAX_SPEED is larger.
    localparam int SPD_MAX = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
    localparam int SPW     = $clog2(SPD_MAX + 1);

    localparam logic [10:0] BR_RESET  = 11'(X_START + BEAN_W);
    localparam logic [10:0] BW        = 11'(BEAN_W);
    localparam logic [10:0] ROW_TOP   = 11'(FLOOR_Y - BEAN_H);
    localparam logic [10:0] ROW_BOT   = 11'(FLOOR_Y - 1);
    localparam logic [10:0] ROW_FLOOR = 11'(FLOOR_Y);

    localparam logic [11:0] RGB_EDGE = 12'h150;
    localparam logic [11:0] RGB_FILL = 12'h3c3;

    logic [FW-1:0]  fcnt;
    logic [SW-1:0]  scnt;
    logic [10:0]    br;
    logic [SPW-1:0] speed;
    logic           frozen;
    logic           hold;
    logic           wrap;

    // ---------------- tick dividers ----------------
    assign tick_fast = (fcnt == FW'(FAST_DIV - 1));
    assign tick_slow = tick_fast && (scnt == SW'(SLOW_RATIO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt <= '0;
        end else if (tick_fast) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt <= '0;
        end else if (tick_slow) begin
            scnt <= '0;
        end else if (tick_fast) begin
            scnt <= scnt + 1'b1;
        end
    end

    // A hit latches the freeze; only reset releases it, even if check_hit drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            frozen <= 1'b0;
        end else if (check_hit) begin
            frozen <= 1'b1;
        end
    end

    assign hold = check_hit || frozen;
    assign wrap = tick_fast && !hold && (br <= 11'(speed));

    // ---------------- position ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            br <= BR_RESET;
        end else if (tick_fast && !hold) begin
            if (br <= 11'(speed)) begin
                br <= BR_RESET;
            end else begin
                br <= br - 11'(speed);
            end
        end
    end

`ifdef BEAN_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            speed <= SPW'(SPEED);
        end else if (wrap && (speed < SPW'(MAX_SPEED))) begin
            speed <= speed + 1'b1;
        end
    end
`else
    assign speed = SPW'(SPEED);
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

    // ---------------- pixel coverage ----------------
    logic [10:0] x11;
    logic [10:0] y11;
    logic        in_box;
    logic        col_first;
    logic        col_last;
    logic        row_first;
    logic        row_last;
    logic        corner;
    logic        outline;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};

    assign in_box = (x11 < br) && ((x11 + BW) >= br) &&
                    (y11 >= ROW_TOP) && (y11 < ROW_FLOOR);

    assign col_first = ((x11 + BW) == br);
    assign col_last  = ((x11 + 11'd1) == br);
    assign row_first = (y11 == ROW_TOP);
    assign row_last  = (y11 == ROW_BOT);

    // Dropping the four corner pixels rounds the bean off.
    assign corner  = (col_first || col_last) && (row_first || row_last);
    assign outline = col_first || col_last || row_first || row_last;

    assign bean     = in_box && !corner;
    assign bean_rgb = bean ? (outline ? RGB_EDGE : RGB_FILL) : 12'h000;

endmodule

// File: tb/tb_bean_obstacle_gen.sv
// Directed bench for bean_obstacle_gen with a short fast divider (FAST_DIV=4).
module tb_bean_obstacle_gen;

    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        check_hit;
    logic        tick_fast;
    logic        tick_slow;
    logic        bean;
    logic [11:0] bean_rgb;
    logic        tick_fast5;
    logic        tick_slow5;
    logic        bean5;
    logic [11:0] bean_rgb5;

    int n_checks;
    int n_err;
    logic [1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bean_obstacle_gen #(.FAST_DIV(4), .SLOW_RATIO(10)) u_dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .check_hit(check_hit),
        .tick_fast(tick_fast), .tick_slow(tick_slow),
        .bean(bean), .bean_rgb(bean_rgb)
    );

    // Second copy starts one pixel further right so it can reach br=5.
    bean_obstacle_gen #(.FAST_DIV(4), .SLOW_RATIO(10), .X_START(641)) u_dut5 (
        .clk(clk), .reset(reset), .x(x), .y(y), .check_hit(check_hit),
        .tick_fast(tick_fast5), .tick_slow(tick_slow5),
        .bean(bean5), .bean_rgb(bean_rgb5)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic probe(input string tag, input int inst, input int px, input int py,
                         input logic exp_bean, input logic [11:0] exp_rgb);
        x = 10'(px);
        y = 10'(py);
        #1;
        if (inst == 0) begin
            check({tag, "_bean"}, 32'(bean), 32'(exp_bean));
            check({tag, "_rgb"}, 32'(bean_rgb), 32'(exp_rgb));
        end else begin
            check({tag, "_bean5"}, 32'(bean5), 32'(exp_bean));
            check({tag, "_rgb5"}, 32'(bean_rgb5), 32'(exp_rgb));
        end
    endtask

    // Waits for n fast ticks; each tick's position update is applied on return.
    task automatic wait_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (!tick_fast && budget < 8) begin
                budget++;
                @(negedge clk);
            end
            if (!tick_fast) begin
                check("tick_timeout", 32'(tick_fast), 32'd1);
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Expected {tick_fast, tick_slow} for cycles 1..n after reset release.
    task automatic run_tick_pattern(input string tag, input int n);
        logic [1:0] got;
        logic [1:0] e;
        for (int c = 1; c <= n; c++) begin
            exp_q.push_back({(c % 4) == 0, (c % 40) == 0});
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            got = {tick_fast, tick_slow};
            e   = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, c), 32'(got), 32'(e));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_err     = 0;
        reset     = 1'b1;
        x         = '0;
        y         = '0;
        check_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and tick cadence
        do_reset();
        probe("rst_off", 0, 639, 390, 1'b0, 12'h000);
        probe("rst_left", 0, 640, 390, 1'b1, 12'h150);
        run_tick_pattern("ticks", 80);

        // First move: 656 -> 640 after 4 ticks
        do_reset();
        wait_ticks(4);
        probe("mv_corner", 0, 639, 399, 1'b0, 12'h000);
        probe("mv_edge", 0, 639, 390, 1'b1, 12'h150);
        probe("mv_right", 0, 640, 390, 1'b0, 12'h000);

        // Colour classes at br=300
        wait_ticks(85);
        probe("c_fill", 0, 292, 388, 1'b1, 12'h3c3);
        probe("c_corner", 0, 284, 376, 1'b0, 12'h000);
        probe("c_xbr", 0, 300, 388, 1'b0, 12'h000);
        probe("c_floor", 0, 292, 400, 1'b0, 12'h000);
        probe("c_lastcol", 0, 299, 388, 1'b1, 12'h150);
        probe("c_firstcol", 0, 284, 377, 1'b1, 12'h150);
        probe("c_toprow", 0, 290, 376, 1'b1, 12'h150);
        probe("c_above", 0, 290, 375, 1'b0, 12'h000);

        // Wrap: main copy at br=4, second copy at br=5
        wait_ticks(74);
        probe("w4_in", 0, 3, 390, 1'b1, 12'h150);
        probe("w4_out", 0, 4, 390, 1'b0, 12'h000);
        probe("w5_in", 1, 4, 390, 1'b1, 12'h150);
        probe("w5_out", 1, 5, 390, 1'b0, 12'h000);
        wait_ticks(1);
        probe("w4_wr_off", 0, 639, 390, 1'b0, 12'h000);
        probe("w4_wr_on", 0, 640, 390, 1'b1, 12'h150);
        probe("w5_br1_in", 1, 0, 390, 1'b1, 12'h150);
        probe("w5_br1_out", 1, 1, 390, 1'b0, 12'h000);
        wait_ticks(1);
        probe("w5_wr_off", 1, 640, 390, 1'b0, 12'h000);
        probe("w5_wr_on", 1, 641, 390, 1'b1, 12'h150);
        probe("w4_next", 0, 651, 390, 1'b1, 12'h150);

        // Freeze at br=652: ticks keep running, motion stays stopped after release
        check_hit = 1'b1;
        wait_ticks(20);
        probe("frz_in", 0, 651, 390, 1'b1, 12'h150);
        probe("frz_out", 0, 652, 390, 1'b0, 12'h000);
        check_hit = 1'b0;
        wait_ticks(2);
        probe("frz_latch_in", 0, 651, 390, 1'b1, 12'h150);
        probe("frz_latch_out", 0, 652, 390, 1'b0, 12'h000);

        // One-clock reset clears position, dividers and freeze
        do_reset();
        probe("rr_off", 0, 639, 390, 1'b0, 12'h000);
        probe("rr_on", 0, 640, 390, 1'b1, 12'h150);
        run_tick_pattern("rr_ticks", 40);
        @(posedge clk);
        #1;
        probe("rr_moved_in", 0, 615, 390, 1'b1, 12'h150);
        probe("rr_moved_out", 0, 616, 390, 1'b0, 12'h000);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bean_obstacle_gen.md
Name: bean_obstacle_gen

Overview:
- Generates the game's timing ticks and the moving "bean" obstacle for the 640x480 VGA goose-runner.
- Divides the 100 MHz system clock into single-cycle 25 Hz and 2.5 Hz tick enables.
- Moves the bean right-to-left along the floor on each 25 Hz tick and freezes it while a hit is flagged.
- Combinationally reports whether the current VGA pixel (x,y) lies on the bean, and its colour.

Parameters:
- FAST_DIV, 4000000: clk cycles per fast tick (100 MHz / 25 Hz).
- SLOW_RATIO, 10: fast ticks per slow tick (25 Hz / 10 = 2.5 Hz).
- X_START, 640: left edge of the bean at reset and after wrap (fully off-screen right).
- BEAN_W, 16: bean width in pixels.
- BEAN_H, 24: bean height in pixels.
- FLOOR_Y, 400: first floor row; the bean occupies rows FLOOR_Y-BEAN_H .. FLOOR_Y-1.
- SPEED, 4: pixels moved per fast tick.
- MAX_SPEED, 12: speed ceiling (used only by the optional feature).

Ports:
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: synchronous, active-high reset.
- x, input, 10: current pixel column.
- y, input, 10: current pixel row.
- check_hit, input, 1: level-sensitive; high means a collision has occurred and motion is frozen.
- tick_fast, output, 1: one-clk pulse at 25 Hz.
- tick_slow, output, 1: one-clk pulse at 2.5 Hz.
- bean, output, 1: high when (x,y) is inside the bean.
- bean_rgb, output, 12: RGB444 colour of the bean pixel; 0 when bean=0.

Behaviour:
- Clock and reset: single clock domain, clock clk. Reset is reset, synchronous, active-high. Reset takes priority over all other events.
- Fast divider:
  - Counter fcnt, 0..FAST_DIV-1. Reset value 0.
  - Increments every clk. When fcnt==FAST_DIV-1, it wraps to 0 and tick_fast=1 for that cycle.
  - tick_fast is combinational from fcnt, so the first pulse occurs FAST_DIV cycles after reset is released.
- Slow divider:
  - Counter scnt, 0..SLOW_RATIO-1. Reset value 0.
  - Advances only on tick_fast. tick_slow = tick_fast AND scnt==SLOW_RATIO-1; scnt then wraps to 0.
  - tick_slow is therefore always coincident with a tick_fast.
- Ticks run continuously regardless of check_hit. They are outputs only; no derived clocks are generated.
- Position register br, 11 bits: the bean's right edge, exclusive. Reset value X_START+BEAN_W.
- Position update on tick_fast when check_hit=0:
  - If br <= speed: br <= X_START+BEAN_W (wrap).
  - Otherwise: br <= br-speed.
- When check_hit=1, br holds. Motion resumes only after reset, even if check_hit later drops.
- Coverage is combinational with zero latency from x, y and br. All comparisons use 11-bit zero-extended arithmetic:
  - bean = (x < br) AND (x+BEAN_W >= br) AND (y >= FLOOR_Y-BEAN_H) AND (y < FLOOR_Y).
- Colour:
  - Outline pixels (first or last column of the bean, first or last row of the bean) are 12'h150.
  - Interior pixels are 12'h3c3.
  - The four corner pixels are excluded (bean=0), giving a rounded look.
  - When bean=0, bean_rgb=12'h000.
- Pixels off-screen (x>=640) may match; the parent masks them through video_on.
- Reset mid-motion or mid-hit: every counter and br returns to its reset value on the next clk, and the speed returns to SPEED.

Optional Feature:
- Macro: BEAN_SPEEDUP_EN.
- Defined: each wrap event increments the speed register by 1, saturating at MAX_SPEED. Reset returns speed to SPEED.
- Undefined: speed is the constant SPEED and MAX_SPEED is unused.

Test Plan:
- Tick timing (FAST_DIV=4, SLOW_RATIO=10): release reset -> tick_fast high on cycles 4, 8, 12, ...; tick_slow high only on cycle 40 and every 40 cycles after; each pulse lasts exactly 1 clk.
- Initial and first move: after reset, br=656 and the probe pixel (x=639, y=390) gives bean=0. After 4 fast ticks br=640; then pixel (x=639, y=399), which is a corner, gives bean=0, and pixel (x=639, y=390) gives bean=1 with bean_rgb=12'h150.
- Colour classes: with br=300, pixel (x=292, y=388) -> bean=1, bean_rgb=12'h3c3; pixel (x=284, y=376) -> bean=0 (corner); pixel (x=300, y=388) -> bean=0; pixel (x=292, y=400) -> bean=0.
- Wrap-around: start from br=4 with SPEED=4 -> the next tick_fast sets br=656; from br=5 -> br=1, then the next tick sets br=656.
- Freeze: hold check_hit=1 for 20 fast ticks -> br unchanged while ticks continue. Then assert reset for 1 clk -> br=656, fcnt=0, scnt=0.
- With BEAN_SPEEDUP_EN: after 3 wraps the speed is 7; after 20 wraps it is capped at 12.
